// File: rtl/bus_sync_pkg.sv
// Shared types and default sizing for the bus synchronizer transmit-side arbiter.
package bus_sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_sync_arb.sv
// Round-robin arbiter feeding a mux-recirculation bus synchronizer; waits for the
// b-domain acknowledge toggle (with timeout) before granting the next requester.
module bus_sync_arb
  import bus_sync_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     a_clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_vld,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [WIDTH-1:0]         sync_data,
  output logic                     sync_ld_pls,
  input  logic                     b_ack_tgl,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned GW       = $clog2(NREQ);
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   idx;
  logic [WIDTH-1:0] slice [NREQ];
  logic            any_req;
  logic            grant_en;
  logic            ack_sync;
  logic            ack_ref;
  logic            ack_seen;
  logic            cnt_last;
  logic [7:0]      cnt;

  sync_2ff u_ack_sync (
    .clk     (a_clk),
    .reset_n (reset_n),
    .d       (b_ack_tgl),
    .q       (ack_sync)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      slice[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan from farthest to nearest so the requester just after last_grant wins.
  always_comb begin
    winner = last_grant;
    idx    = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      idx = GW'((32'(last_grant) + i) % NREQ);
      if (req_vld[idx]) winner = idx;
    end
  end

  assign any_req  = |req_vld;
  assign ack_seen = (ack_sync != ack_ref);
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Acknowledge is tested first so a toggle landing on the final count completes cleanly.
  always_comb begin
    state_nxt   = state;
    grant_en    = 1'b0;
    sync_ld_pls = 1'b0;
    timeout_err = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_en  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        sync_ld_pls = 1'b1;
        state_nxt   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_seen) begin
          state_nxt = IDLE;
        end else if (cnt_last) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (state == LOAD) req_ack[grant_id] = 1'b1;
  end

  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_data  <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
      cnt        <= '0;
      ack_ref    <= 1'b0;
    end else begin
      if (grant_en) begin
        sync_data  <= slice[winner];
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (state == LOAD) begin
        ack_ref <= ack_sync;
        cnt     <= '0;
      end else if (state == WAIT_ACK) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_sync_arb.sv
// Scoreboard bench for bus_sync_arb: directed arbitration/timeout/reset cases plus
// an end-to-end run against a behavioural b-domain receiver on a 3x slower clock.
module tb_bus_sync_arb;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 24;

  logic a_clk = 1'b0;
  logic b_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0]       req_vld  = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ack;
  logic [1:0]            grant_id;
  logic [WIDTH-1:0]      sync_data;
  logic                  sync_ld_pls, busy, timeout_err;
  logic                  b_ack_tgl;
  logic                  dir_tgl = 1'b0;
  logic                  mdl_tgl = 1'b0;
  logic                  e2e     = 1'b0;

  assign b_ack_tgl = e2e ? mdl_tgl : dir_tgl;

  always #5  a_clk = ~a_clk;
  always #15 b_clk = ~b_clk;

  bus_sync_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .a_clk       (a_clk),
    .reset_n     (reset_n),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant_id    (grant_id),
    .sync_data   (sync_data),
    .sync_ld_pls (sync_ld_pls),
    .b_ack_tgl   (b_ack_tgl),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int unsigned id;
    int unsigned data;
  } xfer_t;

  xfer_t       grant_q[$];
  xfer_t       cur;
  int unsigned e2e_q[$];
  int unsigned tmo_q   = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_rcv   = 0;
  int unsigned exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor: every load pulse must match the next expected transfer.
  always @(negedge a_clk) begin
    if (reset_n) begin
      if (sync_ld_pls) begin
        check("load_expected", 32'(grant_q.size() != 0), 1);
        if (grant_q.size() != 0) begin
          cur = grant_q.pop_front();
          check("grant_id", 32'(grant_id), cur.id);
          check("sync_data", 32'(sync_data), cur.data);
          check("req_ack", 32'(req_ack), 32'(1) << cur.id);
        end
      end else if (req_ack != '0) begin
        check("stray_req_ack", 32'(req_ack), 0);
      end
      if (timeout_err) begin
        check("timeout_expected", 32'(tmo_q != 0), 1);
        if (tmo_q != 0) tmo_q--;
      end
    end
  end

  // Behavioural receive side of the mux-recirculation synchronizer.
  logic a_tgl = 1'b0;
  logic bs1 = 1'b0, bs2 = 1'b0, bprev = 1'b0;

  always @(posedge a_clk) if (e2e && sync_ld_pls) a_tgl <= ~a_tgl;

  always @(posedge b_clk) begin
    bs1   <= a_tgl;
    bs2   <= bs1;
    bprev <= bs2;
    if (bs2 != bprev) begin
      check("e2e_expected", 32'(e2e_q.size() != 0), 1);
      if (e2e_q.size() != 0) begin
        exp_w = e2e_q.pop_front();
        check("e2e_word", 32'(sync_data), exp_w);
      end
      n_rcv++;
      mdl_tgl <= ~mdl_tgl;
    end
  end

  task automatic wait_ld(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge a_clk);
      seen = sync_ld_pls;
    end
    check({name, "_ld_seen"}, 32'(seen), 1);
  endtask

  task automatic wait_idle(input string name);
    logic idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge a_clk);
      idle = !busy;
    end
    check({name, "_idle_seen"}, 32'(idle), 1);
  endtask

  task automatic serve(input string name);
    wait_ld(name);
    repeat (3) @(negedge a_clk);
    dir_tgl = ~dir_tgl;
    wait_idle(name);
  endtask

  task automatic push(input int unsigned id, input int unsigned data);
    xfer_t x;
    x.id   = id;
    x.data = data;
    grant_q.push_back(x);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_req_ack"}, 32'(req_ack), 0);
    check({name, "_ld"}, 32'(sync_ld_pls), 0);
    check({name, "_tmo"}, 32'(timeout_err), 0);
    check({name, "_grant_id"}, 32'(grant_id), 0);
    check({name, "_sync_data"}, 32'(sync_data), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned id, d;
    logic got;

    repeat (3) @(negedge a_clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge a_clk);

    // Single request, ack toggle five cycles after load.
    req_data[3:0] = 4'hA;
    req_vld = 4'b0001;
    push(0, 4'hA);
    @(posedge a_clk);
    @(negedge a_clk);
    check("latency_ld", 32'(sync_ld_pls), 1);
    check("latency_ack", 32'(req_ack), 1);
    req_vld = '0;
    repeat (5) @(negedge a_clk);
    dir_tgl = ~dir_tgl;
    @(negedge a_clk);
    check("wait_data_stable", 32'(sync_data), 4'hA);
    @(negedge a_clk);
    check("busy_hold", 32'(busy), 1);
    @(negedge a_clk);
    check("busy_fall", 32'(busy), 0);
    repeat (3) @(negedge a_clk);
    check("idle_data_stable", 32'(sync_data), 4'hA);

    // Ack toggle while idle must not complete the next transfer; dropped request never granted.
    dir_tgl = ~dir_tgl;
    repeat (4) @(negedge a_clk);
    req_data[7:4] = 4'h5;
    req_vld = 4'b0010;
    push(1, 4'h5);
    wait_ld("idle_ack");
    req_vld = '0;
    @(negedge a_clk);
    req_vld = 4'b1000;
    repeat (2) @(negedge a_clk);
    req_vld = '0;
    repeat (4) @(negedge a_clk);
    check("idle_ack_ignored", 32'(busy), 1);
    dir_tgl = ~dir_tgl;
    wait_idle("idle_ack");
    repeat (5) @(negedge a_clk);
    check("dropped_req_no_grant", 32'(busy), 0);

    // Fresh reset, then all four requesting continuously.
    reset_n = 1'b0;
    @(negedge a_clk);
    reset_n = 1'b1;
    @(negedge a_clk);
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    req_vld  = 4'b1111;
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(0, 1);
    for (int i = 0; i < 5; i++) serve("rr");
    req_vld = '0;
    repeat (3) @(negedge a_clk);

    // No acknowledge: timeout on WAIT_ACK cycle TIMEOUT, then the next request is served.
    req_data[11:8] = 4'h7;
    req_vld = 4'b0100;
    push(2, 4'h7);
    tmo_q++;
    wait_ld("tmo");
    req_vld = '0;
    for (int j = 1; j <= int'(TIMEOUT) + 1; j++) begin
      @(negedge a_clk);
      if (j == int'(TIMEOUT) - 1) check("tmo_early", 32'(timeout_err), 0);
      if (j == int'(TIMEOUT)) begin
        check("tmo_pulse", 32'(timeout_err), 1);
        check("tmo_busy", 32'(busy), 1);
      end
      if (j == int'(TIMEOUT) + 1) begin
        check("tmo_one_cycle", 32'(timeout_err), 0);
        check("tmo_idle", 32'(busy), 0);
      end
    end
    req_data[15:12] = 4'h9;
    req_vld = 4'b1000;
    push(3, 4'h9);
    serve("after_tmo");
    req_vld = '0;
    repeat (3) @(negedge a_clk);

    // Ack reaches the synchronizer output on the final count: completion wins.
    req_data[3:0] = 4'h6;
    req_vld = 4'b0001;
    push(0, 4'h6);
    wait_ld("race");
    req_vld = '0;
    for (int j = 1; j <= int'(TIMEOUT) + 1; j++) begin
      @(negedge a_clk);
      if (j == int'(TIMEOUT) - 2) dir_tgl = ~dir_tgl;
      if (j == int'(TIMEOUT)) check("race_no_tmo", 32'(timeout_err), 0);
      if (j == int'(TIMEOUT) + 1) check("race_idle", 32'(busy), 0);
    end
    repeat (3) @(negedge a_clk);

    // Reset during WAIT_ACK aborts; requester 0 wins first afterwards.
    req_data[11:8] = 4'h3;
    req_vld = 4'b0100;
    push(2, 4'h3);
    wait_ld("mid_rst");
    req_vld = '0;
    repeat (2) @(negedge a_clk);
    @(posedge a_clk);
    #2 reset_n = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge a_clk);
    @(posedge a_clk);
    #2 reset_n = 1'b1;
    @(negedge a_clk);
    req_data = {4'hD, 4'hC, 4'hB, 4'hE};
    req_vld  = 4'b1111;
    push(0, 4'hE);
    serve("post_rst");
    req_vld = '0;
    repeat (5) @(negedge a_clk);

    // End-to-end with the slow receive domain.
    e2e = 1'b1;
    repeat (12) @(negedge a_clk);
    for (int n = 0; n < 100; n++) begin
      id = $urandom_range(0, NREQ - 1);
      d  = $urandom_range(0, 15);
      req_data[id*WIDTH +: WIDTH] = WIDTH'(d);
      req_vld = 4'(1 << id);
      push(id, d);
      e2e_q.push_back(d);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge a_clk);
        got = req_ack[id];
      end
      check("e2e_ack_seen", 32'(got), 1);
      req_vld = '0;
    end
    for (int k = 0; k < 400 && (e2e_q.size() != 0 || busy); k++) @(negedge a_clk);
    check("e2e_drained", 32'(e2e_q.size()), 0);
    check("e2e_count", 32'(n_rcv), 100);
    check("grant_q_empty", 32'(grant_q.size()), 0);
    check("tmo_q_empty", 32'(tmo_q), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_sync_arb.md
BUS_SYNC_ARB -- requirements
Module: bus_sync_arb

Interface
REQ-001 Parameter: WIDTH, 4, data bus width carried through the mux-recirculation synchronizer.
REQ-002 Parameter: NREQ, 4, number of a_clk-domain requesters (2..8).
REQ-003 Parameter: TIMEOUT, 255, max a_clk cycles waited for b-domain acknowledge (1..255).
REQ-004 Port: a_clk  input  1  transmit-domain clock; all logic in this block SHALL be clocked by a_clk.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: req_vld  input  NREQ  per-requester transfer request; held high until matching req_ack.
REQ-007 Port: req_data  input  NREQ*WIDTH  per-requester payload, slice i = bits [i*WIDTH +: WIDTH], stable while req_vld[i].
REQ-008 Port: req_ack  output  NREQ  one-cycle accept pulse to granted requester.
REQ-009 Port: grant_id  output  clog2(NREQ)  index of current or last granted requester.
REQ-010 Port: sync_data  output  WIDTH  registered payload driven to synchronizer data input.
REQ-011 Port: sync_ld_pls  output  1  one-cycle load pulse to synchronizer.
REQ-012 Port: b_ack_tgl  input  1  asynchronous toggle from b domain, flips once per captured word.
REQ-013 Port: busy  output  1  high whenever state != IDLE.
REQ-014 Port: timeout_err  output  1  one-cycle pulse when acknowledge not received within TIMEOUT.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, LOAD, WAIT_ACK.
REQ-016 IDLE: if any req_vld bit high, SHALL select winner round-robin, register sync_data <= winner slice, grant_id <= winner, go LOAD; else stay IDLE.
REQ-017 Round-robin: search SHALL start at (last grant + 1) mod NREQ, wrapping; last grant resets to NREQ-1 so requester 0 wins first.
REQ-018 LOAD: lasts exactly one cycle; sync_ld_pls = 1 and req_ack[grant_id] = 1 in this cycle only; ack_ref <= synchronized ack; timeout counter cleared; next state WAIT_ACK.
REQ-019 Latency: req_vld sampled high in IDLE at edge N -> req_ack and sync_ld_pls high in cycle N+1.
REQ-020 sync_data SHALL remain constant from LOAD until next LOAD (never changes in WAIT_ACK or IDLE).
REQ-021 b_ack_tgl SHALL pass through a 2-flop synchronizer in a_clk; only the second-stage output is used.
REQ-022 WAIT_ACK: when synchronized ack != ack_ref, go IDLE (transfer complete); counter increments each cycle otherwise.
REQ-023 WAIT_ACK: when counter reaches TIMEOUT-1 with no ack, pulse timeout_err for one cycle and go IDLE.
REQ-024 Simultaneous ack and timeout in same cycle: ack wins, no timeout_err.
REQ-025 New requests SHALL NOT be granted outside IDLE; minimum spacing between sync_ld_pls pulses is 4 cycles (LOAD, >=2 WAIT_ACK, IDLE).
REQ-026 Ack toggles occurring in IDLE SHALL be ignored; a late ack after timeout may complete the following transfer early (documented limitation, flagged by prior timeout_err).
REQ-027 Requester dropping req_vld before grant is legal; no req_ack issued to it.

Reset
REQ-028 On reset_n low, asynchronously: state IDLE, sync_data 0, grant_id 0, last grant NREQ-1, req_ack 0, sync_ld_pls 0, timeout_err 0, busy 0, counter 0, sync flops and ack_ref 0.
REQ-029 Reset asserted mid-transfer SHALL abort without issuing req_ack or timeout_err; after release, arbitration restarts from requester 0.

Structure
REQ-030 Package bus_sync_pkg SHALL hold the state typedef and default WIDTH/NREQ/TIMEOUT constants.
REQ-031 The 2-flop ack synchronizer SHALL be a sub-module sync_2ff (1-bit, async active-low reset).

Verification
REQ-032 Single request: req_vld=4'b0001, data 0xA, ack toggle after 5 cycles -> sync_ld_pls and req_ack[0] in cycle 1, sync_data=0xA, busy falls 2 cycles after toggle lands.
REQ-033 All four requesting continuously -> grant order 0,1,2,3,0 with one req_ack per transfer.
REQ-034 No ack toggle -> timeout_err pulses exactly at WAIT_ACK cycle TIMEOUT, FSM returns to IDLE, next request served.
REQ-035 Ack toggle reaching sync output in same cycle as final count -> completion, timeout_err stays 0.
REQ-036 reset_n pulsed low during WAIT_ACK -> all outputs zero immediately; after release requester 0 granted first.
REQ-037 End-to-end with bus synchronizer and b_clk 3x slower: 100 random words, all received in order, none lost.
